mem_request_unit: RTL and testbench
===================================

# mem_request_unit

Initiator-side sequencer for the data port of `memoryController`. It accepts one load/store request at a time from the execute/memory stage through a valid/ready handshake and range-checks the address against the ROM and RAM windows. It then drives `we`/`VecOp`/`address`/`wd` to the controller for exactly the required cycles, waits the controller's read latency, and returns the 192-bit read data (or a store acknowledge) as a one-cycle response pulse.

## Interface
- `READ_LATENCY`, default 1: cycles from `address` valid to `rd` valid at the controller; legal range 1–7.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request (high only in IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_vec`  in  1  1 = 192-bit vector access (6 words), 0 = scalar 32-bit.
- `req_addr`  in  32  word address.
- `req_wdata`  in  192  store data; scalar uses bits [31:0].
- `we`  out  1  controller write enable.
- `VecOp`  out  1  controller vector-operation select.
- `address`  out  32  controller data address.
- `wd`  out  192  controller write data.
- `rd`  in  192  controller read data.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_rdata`  out  192  load data; scalar load is zero-extended `rd[31:0]`; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`; the access was rejected.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: `req_ready` = 1. On `req_valid & req_ready`, register `req_*` and evaluate the range check.
  - Legal: go to ISSUE.
  - Illegal: go to RESP with the error flag set.
- Range check (constants from the package):
  - ROM window [ROM_BASE=1000, ROM_BASE+ROM_WORDS=1256) is read-only.
  - RAM window [RAM_BASE=31000, RAM_BASE+RAM_WORDS=32024) is read/write.
  - A vector access requires `addr` and `addr+5` in the same window.
  - Stores to ROM are errors.
  - Addresses below 1000 are the instruction space and are always errors on this port.
- ISSUE, one cycle:
  - Drive `address`, `VecOp`, and `wd`. `wd` is `{160'b0, wdata[31:0]}` for scalar accesses and full `wdata` for vector accesses.
  - `we` = 1 for stores only.
  - Stores go to RESP. Loads go to WAIT.
- WAIT: hold `address`/`VecOp`, keep `we` = 0, and decrement a 3-bit counter loaded with READ_LATENCY−1. When the count reaches 0, capture `rd` and go to RESP.
- RESP: `resp_valid` = 1 for one cycle, then return to IDLE. The controller outputs return to 0 in IDLE.
- `we` is never high for more than one cycle per request, and is never high on an error.
- `rst` mid-operation: the FSM returns to IDLE immediately, outputs are forced to reset values asynchronously, and no response is produced for the aborted request.

## Timing
- Reset values: `req_ready` = 1 (IDLE); `we`, `VecOp`, `resp_valid`, and `resp_err` = 0; `address`, `wd`, and `resp_rdata` = 0.
- Handshake at edge T0:
  - Store: `we` high during cycle T0+1, `resp_valid` at T0+2.
  - Load: `address` valid from T0+1, `rd` sampled at the end of cycle T0+READ_LATENCY, `resp_valid` at T0+1+READ_LATENCY. Default total load latency is 2 cycles.
  - Error: `resp_valid`/`resp_err` at T0+1.
- Throughput: 1 request per 3 cycles for stores, READ_LATENCY+2 cycles for loads, and 2 cycles for errors.
- `req_ready` is low from T0+1 until the cycle after RESP. `req_valid` held high during that time is ignored, and the request is accepted when the unit returns to IDLE.
- `resp_*` are registered outputs and are stable for the whole RESP cycle.

## Structure
- Package `mem_map_pkg`:
  - constants ROM_BASE, ROM_WORDS, RAM_BASE, RAM_WORDS, VEC_WORDS=6, DATA_W=192;
  - enum `mem_req_state_t` {IDLE, ISSUE, WAIT, RESP}.
- Sub-module `mem_range_check`: combinational; inputs `addr`, `we`, and `vec`; output `legal`. Shared later by the instruction-fetch side.
- Top level: FSM, request registers, latency counter, response registers.

## Test plan
- Scalar RAM store then load: store to 31000 with `req_wdata`=3 → `we`=1 for exactly 1 cycle with `address`=31000 and `wd`=3, ack at T0+2. Loading 31000 then returns `resp_rdata`=3 at T0+2.
- Vector store/load: store to 31005 with `req_vec`=1 and `req_wdata`=64'd1234567891123 → `VecOp`=1, `wd` matches the 192-bit data. The following vector load returns the same 192 bits.
- ROM read and errors:
  - Load from 1000 → legal, `VecOp`=0, data = ROM word 0.
  - Store to 1000 → `resp_err`=1 at T0+1, `we` never asserted.
  - Load from 2 → error.
  - Vector load at 32020 (crosses the RAM end) → error.
- Back-to-back requests: `req_valid` held high with 3 queued loads → `req_ready` low between accepts, accepts spaced READ_LATENCY+2 cycles apart, 3 responses delivered in order.
- READ_LATENCY=3 build: load from 31000 → `resp_valid` exactly at T0+4 with data captured on the correct cycle.
- Reset mid-load: assert `rst` during WAIT → all outputs 0 immediately, `req_ready`=1 after release, and no `resp_valid` for the aborted request.

Source files
------------

// File: rtl/mem_map_pkg.sv
// Data-port memory map, access-window helper and request sequencer state encoding.
package mem_map_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned DATA_W    = 192;
  localparam int unsigned VEC_WORDS = 6;

  localparam int unsigned ROM_BASE  = 1000;
  localparam int unsigned ROM_WORDS = 256;
  localparam int unsigned RAM_BASE  = 31000;
  localparam int unsigned RAM_WORDS = 1024;

  // One extra bit so addr + VEC_WORDS - 1 can never wrap back into a window.
  typedef logic [ADDR_W:0] ext_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mem_req_state_t;

  function automatic logic in_window(input ext_addr_t a, input int unsigned base,
                                     input int unsigned words);
    return (a >= ext_addr_t'(base)) && (a < ext_addr_t'(base + words));
  endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Request/response handshake between the execute/memory stage and the request unit.
interface mem_request_unit_if;
  import mem_map_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic                req_vec;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic                resp_valid;
  logic [DATA_W-1:0]   resp_rdata;
  logic                resp_err;

  modport master (
    output req_valid, req_we, req_vec, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_vec, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_range_check.sv
// Combinational legality check of a data access against the ROM and RAM windows.
module mem_range_check
  import mem_map_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic              vec,
  output logic              legal
);

  ext_addr_t first;
  ext_addr_t last;

  assign first = {1'b0, addr};
  assign last  = first + (vec ? ext_addr_t'(VEC_WORDS - 1) : ext_addr_t'(0));

  // Both ends of the access must fall in the same window; ROM never accepts stores.
  assign legal = (in_window(first, ROM_BASE, ROM_WORDS) && in_window(last, ROM_BASE, ROM_WORDS) && !we)
              || (in_window(first, RAM_BASE, RAM_WORDS) && in_window(last, RAM_BASE, RAM_WORDS));

endmodule

// File: rtl/mem_request_unit.sv
// Initiator-side sequencer for the memory controller data port: one request at a time,
// range-checked, with a single-cycle issue, read-latency wait and a registered response pulse.
module mem_request_unit
  import mem_map_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
)
(
  input  logic              clk,
  input  logic              rst,
  mem_request_unit_if.slave req,
  output logic              we,
  output logic              VecOp,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] wd,
  input  logic [DATA_W-1:0] rd
);

  localparam logic [2:0] LAT_INIT = 3'(READ_LATENCY - 1);

  mem_req_state_t    state_reg, state_next;
  logic              store_reg, store_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic              vec_op_reg, vec_op_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] wd_reg, wd_next;
  logic              resp_valid_reg, resp_valid_next;
  logic              resp_err_reg, resp_err_next;
  logic [DATA_W-1:0] resp_rdata_reg, resp_rdata_next;
  logic              legal;

  mem_range_check u_range_check (
    .addr  (req.req_addr),
    .we    (req.req_we),
    .vec   (req.req_vec),
    .legal (legal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      store_reg      <= 1'b0;
      cnt_reg        <= '0;
      we_reg         <= 1'b0;
      vec_op_reg     <= 1'b0;
      address_reg    <= '0;
      wd_reg         <= '0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= '0;
    end else begin
      state_reg      <= state_next;
      store_reg      <= store_next;
      cnt_reg        <= cnt_next;
      we_reg         <= we_next;
      vec_op_reg     <= vec_op_next;
      address_reg    <= address_next;
      wd_reg         <= wd_next;
      resp_valid_reg <= resp_valid_next;
      resp_err_reg   <= resp_err_next;
      resp_rdata_reg <= resp_rdata_next;
    end
  end

  // Bus and response registers are loaded one state early so every output is a flop.
  always_comb begin
    state_next      = state_reg;
    store_next      = store_reg;
    cnt_next        = cnt_reg;
    we_next         = 1'b0;
    vec_op_next     = vec_op_reg;
    address_next    = address_reg;
    wd_next         = '0;
    resp_valid_next = 1'b0;
    resp_err_next   = 1'b0;
    resp_rdata_next = '0;

    case (state_reg)
      IDLE: begin
        vec_op_next  = 1'b0;
        address_next = '0;
        if (req.req_valid) begin
          store_next = req.req_we;
          cnt_next   = LAT_INIT;
          if (legal) begin
            state_next   = ISSUE;
            we_next      = req.req_we;
            vec_op_next  = req.req_vec;
            address_next = req.req_addr;
            wd_next      = req.req_vec ? req.req_wdata
                                       : {{(DATA_W - WORD_W){1'b0}}, req.req_wdata[WORD_W-1:0]};
          end else begin
            state_next      = RESP;
            resp_valid_next = 1'b1;
            resp_err_next   = 1'b1;
          end
        end
      end
      ISSUE, WAIT: begin
        if (state_reg == ISSUE && store_reg) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          vec_op_next     = 1'b0;
          address_next    = '0;
        end else if (cnt_reg == 3'd0) begin
          state_next      = RESP;
          resp_valid_next = 1'b1;
          resp_rdata_next = vec_op_reg ? rd : {{(DATA_W - WORD_W){1'b0}}, rd[WORD_W-1:0]};
          vec_op_next     = 1'b0;
          address_next    = '0;
        end else begin
          state_next = WAIT;
          cnt_next   = cnt_reg - 3'd1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign req.req_ready  = (state_reg == IDLE);
  assign req.resp_valid = resp_valid_reg;
  assign req.resp_err   = resp_err_reg;
  assign req.resp_rdata = resp_rdata_reg;

  assign we      = we_reg;
  assign VecOp   = vec_op_reg;
  assign address = address_reg;
  assign wd      = wd_reg;

endmodule

// File: tb/tb_mem_request_unit.sv
// Directed bench: two request units (read latency 1 and 3) sharing a behavioural controller memory.
module tb_mem_request_unit;

  logic clk;
  logic rst;

  mem_request_unit_if bus_a();
  mem_request_unit_if bus_b();

  logic         we_a, vecop_a, we_b, vecop_b;
  logic [31:0]  address_a, address_b;
  logic [191:0] wd_a, wd_b, rd_a, rd_b;

  mem_request_unit #(.READ_LATENCY(1)) dut_a (
    .clk(clk), .rst(rst), .req(bus_a),
    .we(we_a), .VecOp(vecop_a), .address(address_a), .wd(wd_a), .rd(rd_a)
  );

  mem_request_unit #(.READ_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst), .req(bus_b),
    .we(we_b), .VecOp(vecop_b), .address(address_b), .wd(wd_b), .rd(rd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: RAM words preset to A5A5_0000|offset, ROM word i reads C0DE_0000|i.
  logic [31:0]  ram [1024];
  logic [191:0] pipe_b [2];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    logic [31:0] off;
    if (a >= 32'd31000 && a < 32'd32024) begin
      off = a - 32'd31000;
      return ram[off[9:0]];
    end else if (a >= 32'd1000 && a < 32'd1256) begin
      return 32'hC0DE0000 | (a - 32'd1000);
    end
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [191:0] line_at(input logic [31:0] a);
    logic [191:0] l;
    for (int k = 0; k < 6; k++) l[k*32 +: 32] = word_at(a + 32'(k));
    return l;
  endfunction

  always_comb rd_a = line_at(address_a);
  assign rd_b = pipe_b[1];

  always @(posedge clk) begin
    pipe_b[0] <= line_at(address_b);
    pipe_b[1] <= pipe_b[0];
  end

  always @(posedge clk) begin
    logic [31:0] wa;
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'hA5A50000 | 32'(i);
    end else begin
      for (int k = 0; k < 6; k++) begin
        wa = address_a + 32'(k);
        if (we_a && (vecop_a || k == 0) && wa >= 32'd31000 && wa < 32'd32024)
          ram[wa - 32'd31000] <= wd_a[k*32 +: 32];
        wa = address_b + 32'(k);
        if (we_b && (vecop_b || k == 0) && wa >= 32'd31000 && wa < 32'd32024)
          ram[wa - 32'd31000] <= wd_b[k*32 +: 32];
      end
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel_b, input logic v, input logic w, input logic vec,
                       input logic [31:0] a, input logic [191:0] wdata);
    if (sel_b) begin
      bus_b.req_valid = v; bus_b.req_we = w; bus_b.req_vec = vec;
      bus_b.req_addr = a; bus_b.req_wdata = wdata;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = w; bus_a.req_vec = vec;
      bus_a.req_addr = a; bus_a.req_wdata = wdata;
    end
  endtask

  task automatic sample(input bit sel_b, output logic s_we, output logic s_vec,
                        output logic [31:0] s_addr, output logic [191:0] s_wd,
                        output logic s_rv, output logic s_err,
                        output logic [191:0] s_rdata, output logic s_ready);
    if (sel_b) begin
      s_we = we_b; s_vec = vecop_b; s_addr = address_b; s_wd = wd_b;
      s_rv = bus_b.resp_valid; s_err = bus_b.resp_err; s_rdata = bus_b.resp_rdata;
      s_ready = bus_b.req_ready;
    end else begin
      s_we = we_a; s_vec = vecop_a; s_addr = address_a; s_wd = wd_a;
      s_rv = bus_a.resp_valid; s_err = bus_a.resp_err; s_rdata = bus_a.resp_rdata;
      s_ready = bus_a.req_ready;
    end
  endtask

  // One request from an idle unit; lat is counted so that 1 is the cycle right after the handshake.
  task automatic run_req(input string tag, input bit sel_b, input logic w, input logic vec,
                         input logic [31:0] a, input logic [191:0] wdata, input int exp_lat,
                         input logic exp_err, input logic [191:0] exp_rdata);
    int           lat = 0;
    int           we_cnt = 0;
    logic [191:0] rdata = '0, wd_seen = '0, s_wd, s_rdata;
    logic         err = 1'b0, v1 = 1'b0, ready1 = 1'b1;
    logic [31:0]  a1 = '0, s_addr;
    logic         s_we, s_vec, s_rv, s_err, s_ready;
    drive(sel_b, 1'b1, w, vec, a, wdata);
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) drive(sel_b, 1'b0, 1'b0, 1'b0, 32'd0, '0);
      sample(sel_b, s_we, s_vec, s_addr, s_wd, s_rv, s_err, s_rdata, s_ready);
      if (c == 1) begin a1 = s_addr; v1 = s_vec; ready1 = s_ready; end
      if (s_we) begin we_cnt++; wd_seen = s_wd; end
      if (s_rv) begin lat = c; rdata = s_rdata; err = s_err; break; end
    end
    check({tag, "_latency"}, 192'(lat), 192'(exp_lat));
    check({tag, "_err"}, 192'(err), 192'(exp_err));
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_we_cycles"}, 192'(we_cnt), 192'((w && !exp_err) ? 1 : 0));
    check({tag, "_ready_busy"}, 192'(ready1), 192'(0));
    if (!exp_err) begin
      check({tag, "_address"}, 192'(a1), 192'(a));
      check({tag, "_vecop"}, 192'(v1), 192'(vec));
    end
    if (w && !exp_err)
      check({tag, "_wd"}, wd_seen, vec ? wdata : {160'b0, wdata[31:0]});
    tick();
    sample(sel_b, s_we, s_vec, s_addr, s_wd, s_rv, s_err, s_rdata, s_ready);
    check({tag, "_idle_ready"}, 192'(s_ready), 192'(1));
    check({tag, "_idle_resp_valid"}, 192'(s_rv), 192'(0));
    check({tag, "_idle_address"}, 192'(s_addr), 192'(0));
    $display("txn %s: addr=%0d we=%0b vec=%0b lat=%0d err=%0b rdata=%0h", tag, a, w, vec, lat, err, rdata);
  endtask

  localparam logic [191:0] VDATA = 192'(64'd1234567891123);

  initial begin
    logic [31:0]  bb_addr [3];
    logic [191:0] bb_exp [3];
    logic [191:0] bb_got [3];
    int           bb_acc [3];
    int           bb_rsp [3];
    int           na, nr, rv_cnt;
    logic         rdy_prev;

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, '0);
    tick(); tick(); tick();
    check("reset_ready", 192'(bus_a.req_ready), 192'(1));
    check("reset_we", 192'(we_a), 192'(0));
    check("reset_vecop", 192'(vecop_a), 192'(0));
    check("reset_address", 192'(address_a), 192'(0));
    check("reset_wd", wd_a, '0);
    check("reset_resp_valid", 192'(bus_a.resp_valid), 192'(0));
    check("reset_resp_err", 192'(bus_a.resp_err), 192'(0));
    check("reset_resp_rdata", bus_a.resp_rdata, '0);
    rst = 1'b0;
    tick();

    run_req("st_31000", 1'b0, 1'b1, 1'b0, 32'd31000, 192'd3, 2, 1'b0, '0);
    run_req("ld_31000", 1'b0, 1'b0, 1'b0, 32'd31000, '0, 2, 1'b0, 192'd3);
    run_req("vst_31005", 1'b0, 1'b1, 1'b1, 32'd31005, VDATA, 2, 1'b0, '0);
    run_req("vld_31005", 1'b0, 1'b0, 1'b1, 32'd31005, '0, 2, 1'b0, VDATA);
    run_req("ld_31005", 1'b0, 1'b0, 1'b0, 32'd31005, '0, 2, 1'b0, 192'h71FB08B3);
    run_req("ld_rom_1000", 1'b0, 1'b0, 1'b0, 32'd1000, '0, 2, 1'b0, 192'hC0DE0000);
    run_req("st_rom_1000", 1'b0, 1'b1, 1'b0, 32'd1000, 192'd9, 1, 1'b1, '0);
    run_req("ld_2", 1'b0, 1'b0, 1'b0, 32'd2, '0, 1, 1'b1, '0);
    run_req("vld_32020", 1'b0, 1'b0, 1'b1, 32'd32020, '0, 1, 1'b1, '0);
    run_req("vld_32018", 1'b0, 1'b0, 1'b1, 32'd32018, '0, 2, 1'b0,
            {32'hA5A503FF, 32'hA5A503FE, 32'hA5A503FD, 32'hA5A503FC, 32'hA5A503FB, 32'hA5A503FA});
    run_req("ld_999", 1'b0, 1'b0, 1'b0, 32'd999, '0, 1, 1'b1, '0);
    run_req("ld_1255", 1'b0, 1'b0, 1'b0, 32'd1255, '0, 2, 1'b0, 192'hC0DE00FF);
    run_req("ld_1256", 1'b0, 1'b0, 1'b0, 32'd1256, '0, 1, 1'b1, '0);
    run_req("vld_1251", 1'b0, 1'b0, 1'b1, 32'd1251, '0, 1, 1'b1, '0);
    run_req("vld_1250", 1'b0, 1'b0, 1'b1, 32'd1250, '0, 2, 1'b0,
            {32'hC0DE00FF, 32'hC0DE00FE, 32'hC0DE00FD, 32'hC0DE00FC, 32'hC0DE00FB, 32'hC0DE00FA});

    // Three loads queued with req_valid held high.
    bb_addr[0] = 32'd31000; bb_exp[0] = 192'd3;
    bb_addr[1] = 32'd1000;  bb_exp[1] = 192'hC0DE0000;
    bb_addr[2] = 32'd31006; bb_exp[2] = 192'h11F;
    for (int i = 0; i < 3; i++) begin bb_acc[i] = 0; bb_rsp[i] = 0; bb_got[i] = '0; end
    na = 0; nr = 0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, bb_addr[0], '0);
    rdy_prev = bus_a.req_ready;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (rdy_prev && bus_a.req_valid) begin
        if (na < 3) bb_acc[na] = c;
        na++;
        if (na < 3) drive(1'b0, 1'b1, 1'b0, 1'b0, bb_addr[na], '0);
        else        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0);
      end
      if (bus_a.resp_valid) begin
        if (nr < 3) begin bb_rsp[nr] = c; bb_got[nr] = bus_a.resp_rdata; end
        nr++;
      end
      rdy_prev = bus_a.req_ready;
      if (nr >= 3) break;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0);
    check("bb_accepts", 192'(na), 192'(3));
    check("bb_responses", 192'(nr), 192'(3));
    check("bb_spacing_01", 192'(bb_acc[1] - bb_acc[0]), 192'(3));
    check("bb_spacing_12", 192'(bb_acc[2] - bb_acc[1]), 192'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bb_resp_cycle_%0d", i), 192'(bb_rsp[i] - bb_acc[i]), 192'(1));
      check($sformatf("bb_rdata_%0d", i), bb_got[i], bb_exp[i]);
      $display("txn bb_%0d: addr=%0d accept=%0d resp=%0d rdata=%0h", i, bb_addr[i], bb_acc[i], bb_rsp[i], bb_got[i]);
    end
    tick();

    run_req("b_ld_31000", 1'b1, 1'b0, 1'b0, 32'd31000, '0, 4, 1'b0, 192'd3);
    run_req("b_vld_31005", 1'b1, 1'b0, 1'b1, 32'd31005, '0, 4, 1'b0, VDATA);
    run_req("b_st_31001", 1'b1, 1'b1, 1'b0, 32'd31001, 192'd7, 2, 1'b0, '0);
    run_req("b_ld_31001", 1'b1, 1'b0, 1'b0, 32'd31001, '0, 4, 1'b0, 192'd7);
    run_req("b_ld_500", 1'b1, 1'b0, 1'b0, 32'd500, '0, 1, 1'b1, '0);

    // Reset asserted while unit B is waiting on the controller.
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'd31000, '0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, '0);
    tick();
    check("rst_pre_address", 192'(address_b), 192'(31000));
    check("rst_pre_ready", 192'(bus_b.req_ready), 192'(0));
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_address", 192'(address_b), 192'(0));
    check("rst_async_we", 192'(we_b), 192'(0));
    check("rst_async_vecop", 192'(vecop_b), 192'(0));
    check("rst_async_ready", 192'(bus_b.req_ready), 192'(1));
    check("rst_async_resp_valid", 192'(bus_b.resp_valid), 192'(0));
    check("rst_async_resp_rdata", bus_b.resp_rdata, '0);
    tick(); tick();
    rst = 1'b0;
    rv_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (bus_b.resp_valid) rv_cnt++;
    end
    check("rst_no_response", 192'(rv_cnt), 192'(0));
    check("rst_ready_after", 192'(bus_b.req_ready), 192'(1));
    $display("txn rst_mid_wait: aborted load 31000, responses after release=%0d", rv_cnt);
    run_req("b_ld_after_rst", 1'b1, 1'b0, 1'b0, 32'd31000, '0, 4, 1'b0, 192'hA5A50000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
